nec_ir_tx: RTL and testbench
============================

Name: nec_ir_tx

Overview:
- NEC-format infrared transmitter; the transmit end of the PPM remote-control link the car's IR decoder receives.
- Encodes one 8-bit address and 8-bit command (or a repeat code) into an NEC frame.
- Drives an IR LED with a carrier-modulated output and also provides the unmodulated envelope.
- Used on the remote/test board and as a loopback stimulus for the car's IR receive path. Runs from the 1 MHz system clock.

Parameters:
- CLK_PER_US, 1, clock cycles per microsecond; all NEC durations below are in µs and are multiplied by this value.
- CARRIER_DIV, 26, carrier period in clock cycles (about 38 kHz at 1 MHz).
- CARRIER_HIGH, 9, carrier high cycles per period (about 1/3 duty); must be less than CARRIER_DIV.
- GAP_US, 40000, trailing idle time after the stop mark before the frame completes.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  single-cycle transmit request.
- rep  input  1  sampled with start; 1 = send repeat code, 0 = send full frame.
- addr  input  8  address byte, sampled with start.
- cmd  input  8  command byte, sampled with start.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame, including its gap, completes.
- ir_env  output  1  envelope; 1 = mark.
- ir_out  output  1  modulated LED drive, equal to ir_env AND carrier.

Behaviour:
- Reset (asynchronous, takes effect mid-frame too): busy, done, ir_env and ir_out = 0; state IDLE; all counters 0.
- Accept condition: start=1 while busy=0. On accept, latch rep, addr and cmd.
  - Full frame data is a 32-bit shift word sent LSB first: {~cmd, cmd, ~addr, addr}, so addr bit0 goes out first.
  - start while busy=1 is ignored. Inputs are don't-care outside the accept cycle.
- Latency: start accepted in cycle N; from cycle N+1 busy=1, ir_env=1, state LEAD_MARK.
- States and durations (exact cycle counts = µs × CLK_PER_US):
  - IDLE -> LEAD_MARK on accept.
  - LEAD_MARK, 9000 µs, env=1 -> LEAD_SPACE.
  - LEAD_SPACE, env=0: 4500 µs when rep=0 -> BIT_MARK; 2250 µs when rep=1 -> STOP_MARK.
  - BIT_MARK, 560 µs, env=1 -> BIT_SPACE.
  - BIT_SPACE, env=0: 560 µs for a 0 bit, 1690 µs for a 1 bit.
    - Then shift the word right and increment the bit counter.
    - Next state: -> BIT_MARK while fewer than 32 bits have been sent, else -> STOP_MARK.
  - STOP_MARK, 560 µs, env=1 -> GAP.
  - GAP, GAP_US, env=0 -> IDLE.
    - done=1 for exactly the first IDLE cycle; busy=0 in that same cycle.
    - A start in that cycle is accepted, giving back-to-back frames.
- Duration counter: 24 bits; it reloads or clears on every state change, with no off-by-one: each state lasts exactly its cycle count.
- Carrier:
  - Counter 0..CARRIER_DIV-1, wrapping to 0.
  - Forced to 0 on the first cycle of every mark, so each mark starts with carrier high.
  - carrier = (count < CARRIER_HIGH).
  - ir_out=0 whenever ir_env=0.
- Outputs are registered, with no combinational path from inputs to outputs.
- Full-frame length = 13500 + 32×560 + Σ(bit ? 1690 : 560) + 560 µs, plus GAP_US.

Test Plan:
- Reset: assert rst_n=0 mid-run -> busy, done, ir_env, ir_out = 0 immediately; after release they stay 0 with no start.
- Full frame with addr=0x00, cmd=0x16, rep=0, start in cycle N:
  - ir_env: 9000 high, 4500 low, then bits 0×8, 1×8, 0,1,1,0,1,0,0,0, 1,0,0,1,0,1,1,1 with 560 marks and 560/1690 spaces, then a 560 stop mark.
  - Stop mark ends at N+1+67980; done pulses at cycle N+1+107980.
- Carrier: during the lead mark, ir_out repeats 9 cycles high and 17 low from the first mark cycle, giving 346 full periods plus 4 high cycles. ir_out=0 in every space.
- Repeat code: rep=1 -> 9000 high, 2250 low, 560 high, 40000 low; done at N+1+51810; addr and cmd do not affect the output.
- Handshake:
  - start pulses during busy (lead, bit and gap states) are ignored and the frame is unaltered.
  - start with addr=0x55, cmd=0xAA in the done cycle -> the next lead mark begins the following cycle with the new data.
- Reset during a BIT_SPACE -> outputs 0 at once; a subsequent start transmits a complete fresh frame from LEAD_MARK.

Source files
------------

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends an address/command frame or a repeat code as a
// pulse-distance envelope, plus a carrier-modulated LED drive. All outputs are registered.
module nec_ir_tx #(
    parameter int CLK_PER_US   = 1,
    parameter int CARRIER_DIV  = 26,
    parameter int CARRIER_HIGH = 9,
    parameter int GAP_US       = 40000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rep,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_out
);
    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    // Terminal values of the duration counter (cycle count minus one).
    localparam logic [23:0] LEAD_MARK_M1  = 24'(9000 * CLK_PER_US - 1);
    localparam logic [23:0] LEAD_SPACE_M1 = 24'(4500 * CLK_PER_US - 1);
    localparam logic [23:0] REP_SPACE_M1  = 24'(2250 * CLK_PER_US - 1);
    localparam logic [23:0] SHORT_M1      = 24'(560 * CLK_PER_US - 1);
    localparam logic [23:0] LONG_M1       = 24'(1690 * CLK_PER_US - 1);
    localparam logic [23:0] GAP_M1        = 24'(GAP_US * CLK_PER_US - 1);

    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CAR_HIGH = CW'(CARRIER_HIGH);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t        state_q;
    logic [23:0]   dur_q;
    logic [23:0]   dur_end;
    logic          dur_last;
    logic [CW-1:0] carr_q;
    logic [CW-1:0] carr_d;
    logic [4:0]    bit_cnt_q;
    logic [31:0]   shift_q;
    logic          rep_q;
    logic          busy_q;
    logic          done_q;
    logic          env_q;
    logic          out_q;

    always_comb begin
        dur_end = '0;
        unique case (state_q)
            LEAD_MARK:           dur_end = LEAD_MARK_M1;
            LEAD_SPACE:          dur_end = rep_q ? REP_SPACE_M1 : LEAD_SPACE_M1;
            BIT_MARK, STOP_MARK: dur_end = SHORT_M1;
            BIT_SPACE:           dur_end = shift_q[0] ? LONG_M1 : SHORT_M1;
            GAP:                 dur_end = GAP_M1;
            default:             dur_end = '0;
        endcase
    end

    assign dur_last = (dur_q == dur_end);
    assign carr_d   = (carr_q == CAR_LAST) ? '0 : carr_q + CW'(1);

    // Every mark is entered with the carrier counter at 0, so its first cycle drives high.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            carr_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rep_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            env_q     <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    state_q   <= LEAD_MARK;
                    busy_q    <= 1'b1;
                    env_q     <= 1'b1;
                    out_q     <= 1'b1;
                    carr_q    <= '0;
                    dur_q     <= '0;
                    rep_q     <= rep;
                    shift_q   <= {~cmd, cmd, ~addr, addr};
                    bit_cnt_q <= '0;
                end
            end else if (!dur_last) begin
                dur_q <= dur_q + 24'd1;
                if (env_q) begin
                    carr_q <= carr_d;
                    out_q  <= (carr_d < CAR_HIGH);
                end
            end else begin
                dur_q  <= '0;
                carr_q <= '0;
                unique case (state_q)
                    LEAD_MARK: begin
                        state_q <= LEAD_SPACE;
                        env_q   <= 1'b0;
                        out_q   <= 1'b0;
                    end
                    LEAD_SPACE: begin
                        state_q <= rep_q ? STOP_MARK : BIT_MARK;
                        env_q   <= 1'b1;
                        out_q   <= 1'b1;
                    end
                    BIT_MARK: begin
                        state_q <= BIT_SPACE;
                        env_q   <= 1'b0;
                        out_q   <= 1'b0;
                    end
                    BIT_SPACE: begin
                        state_q   <= (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                        shift_q   <= {1'b0, shift_q[31:1]};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        env_q     <= 1'b1;
                        out_q     <= 1'b1;
                    end
                    STOP_MARK: begin
                        state_q <= GAP;
                        env_q   <= 1'b0;
                        out_q   <= 1'b0;
                    end
                    GAP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        env_q   <= 1'b0;
                        out_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ir_env = env_q;
    assign ir_out = out_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx: walks whole frames segment by segment against
// hand-computed NEC timings, with a shortened trailing gap to keep runs short.
module tb_nec_ir_tx;
    localparam int GAP = 20;

    logic       clk_in;
    logic       rst_n;
    logic       start;
    logic       rep;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       busy;
    logic       done;
    logic       ir_env;
    logic       ir_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    nec_ir_tx #(
        .CLK_PER_US  (1),
        .CARRIER_DIV (26),
        .CARRIER_HIGH(9),
        .GAP_US      (GAP)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .start (start),
        .rep   (rep),
        .addr  (addr),
        .cmd   (cmd),
        .busy  (busy),
        .done  (done),
        .ir_env(ir_env),
        .ir_out(ir_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // Holds for len cycles: envelope e, busy b, no done; marks carry 9-high/17-low carrier.
    task automatic seg(input logic e, input int len, input logic b, input bit poke, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            logic eo;
            eo = e && ((i % 26) < 9);
            if (ir_env !== e || ir_out !== eo || busy !== b || done !== 1'b0) bad++;
            if (poke && i == len / 2) begin
                start = 1'b1; rep = 1'b1; addr = 8'hFF; cmd = 8'hFF;
            end else if (poke && i == len / 2 + 1) begin
                start = 1'b0;
            end
            @(posedge clk_in); #1;
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s: observed %0d bad cycles, expected 0", tag, bad);
        end
    endtask

    task automatic do_start(input logic r, input logic [7:0] a, input logic [7:0] c);
        start = 1'b1; rep = r; addr = a; cmd = c;
        @(posedge clk_in); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({busy, done, ir_env, ir_out} === 4'b0000) else begin
            errors++;
            $error("FAIL %s: observed %b expected 0000", tag, {busy, done, ir_env, ir_out});
        end
    endtask

    task automatic check_done(input int len, input string tag);
        checks++;
        assert ({done, busy, ir_env, ir_out} === 4'b1000) else begin
            errors++;
            $error("FAIL %s_flags: observed %b expected 1000", tag, {done, busy, ir_env, ir_out});
        end
        checks++;
        assert ((cyc - t0) === len) else begin
            errors++;
            $error("FAIL %s_time: observed %0d expected %0d", tag, cyc - t0, len);
        end
    endtask

    task automatic send_bits(input logic [31:0] w);
        for (int k = 0; k < 32; k++) begin
            seg(1'b1, 560, 1'b1, 1'b0, $sformatf("bit%0d_mark", k));
            seg(1'b0, w[k] ? 1690 : 560, 1'b1, (k == 5), $sformatf("bit%0d_space", k));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rep = 1'b0; addr = 8'h00; cmd = 8'h00;
        repeat (3) @(posedge clk_in);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        seg(1'b0, 5, 1'b0, 1'b0, "idle_after_reset");

        // Reset mid-frame clears outputs without waiting for an edge.
        do_start(1'b0, 8'hA5, 8'h3C);
        seg(1'b1, 20, 1'b1, 1'b0, "early_lead");
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_lead");
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        seg(1'b0, 5, 1'b0, 1'b0, "idle_after_mid_reset");

        // Full frame addr=0x00 cmd=0x16; word {E9,16,FF,00} LSB first; ignored starts inside.
        do_start(1'b0, 8'h00, 8'h16);
        seg(1'b1, 9000, 1'b1, 1'b1, "f1_lead_mark");
        seg(1'b0, 4500, 1'b1, 1'b0, "f1_lead_space");
        send_bits(32'hE916_FF00);
        checks++;
        assert ((cyc - t0) === 67420) else begin
            errors++;
            $error("FAIL f1_bits_end: observed %0d expected 67420", cyc - t0);
        end
        seg(1'b1, 560, 1'b1, 1'b0, "f1_stop_mark");
        checks++;
        assert ((cyc - t0) === 67980) else begin
            errors++;
            $error("FAIL f1_stop_end: observed %0d expected 67980", cyc - t0);
        end
        seg(1'b0, GAP, 1'b1, 1'b1, "f1_gap");
        check_done(67980 + GAP, "f1_done");

        // Back-to-back start in the done cycle with new data; addr bit0=1 gives a long space.
        do_start(1'b0, 8'h55, 8'hAA);
        seg(1'b1, 9000, 1'b1, 1'b0, "f2_lead_mark");
        seg(1'b0, 4500, 1'b1, 1'b0, "f2_lead_space");
        seg(1'b1, 560, 1'b1, 1'b0, "f2_bit0_mark");
        seg(1'b0, 600, 1'b1, 1'b0, "f2_bit0_space_long");
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_bit_space");
        repeat (2) @(posedge clk_in);
        #1 check_zero("held_in_reset");
        rst_n = 1'b1;
        seg(1'b0, 5, 1'b0, 1'b0, "idle_after_bit_reset");

        // Repeat code from a fresh start; address and command must not matter.
        do_start(1'b1, 8'h12, 8'h34);
        seg(1'b1, 9000, 1'b1, 1'b0, "rep_lead_mark");
        seg(1'b0, 2250, 1'b1, 1'b0, "rep_lead_space");
        seg(1'b1, 560, 1'b1, 1'b0, "rep_stop_mark");
        seg(1'b0, GAP, 1'b1, 1'b0, "rep_gap");
        check_done(11810 + GAP, "rep_done");
        @(posedge clk_in); #1;
        check_zero("after_rep_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
